// File: rtl/match_ctrl_if.sv
// rtl/match_ctrl_if.sv - handshake/score bundle between field logic, score counters and match_ctrl
interface match_ctrl_if;
    logic       start;
    logic       goal_l_in;
    logic       goal_r_in;
    logic [3:0] score_l1;
    logic [3:0] score_l0;
    logic [3:0] score_r1;
    logic [3:0] score_r0;
    logic       goal_l;
    logic       goal_r;
    logic       dis_score;
    logic       serve;
    logic       ball_en;
    logic [2:0] state;
    logic [1:0] winner;

    modport slave (
        input  start,
        input  goal_l_in,
        input  goal_r_in,
        input  score_l1,
        input  score_l0,
        input  score_r1,
        input  score_r0,
        output goal_l,
        output goal_r,
        output dis_score,
        output serve,
        output ball_en,
        output state,
        output winner
    );

    modport master (
        output start,
        output goal_l_in,
        output goal_r_in,
        output score_l1,
        output score_l0,
        output score_r1,
        output score_r0,
        input  goal_l,
        input  goal_r,
        input  dis_score,
        input  serve,
        input  ball_en,
        input  state,
        input  winner
    );
endinterface

// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - rally/match sequencer: goal pulses, score enable, post-goal pause, winner
module match_ctrl #(
    parameter int WIN_SCORE    = 5,
    parameter int PAUSE_CYCLES = 100000000,
    parameter int CNT_W        = 27
) (
    input  logic         clk,
    input  logic         rst,
    match_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SERVE  = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_SCORED = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;

    localparam logic [6:0]       WIN_7      = 7'(WIN_SCORE);
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             start_q, goal_l_in_q, goal_r_in_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             goal_l_q, goal_l_d;
    logic             goal_r_q, goal_r_d;
    logic             dis_score_q, dis_score_d;
    logic             serve_q, serve_d;
    logic             ball_en_q, ball_en_d;
    logic [1:0]       winner_q, winner_d;

    logic       start_rise, goal_l_rise, goal_r_rise;
    logic [6:0] score_l, score_r;

    assign start_rise  = bus.start     & ~start_q;
    assign goal_l_rise = bus.goal_l_in & ~goal_l_in_q;
    assign goal_r_rise = bus.goal_r_in & ~goal_r_in_q;

    // Decimal score value from the counters' BCD digits (max 99 fits in 7 bits)
    assign score_l = ({3'b000, bus.score_l1} * 7'd10) + {3'b000, bus.score_l0};
    assign score_r = ({3'b000, bus.score_r1} * 7'd10) + {3'b000, bus.score_r0};

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        goal_l_d = 1'b0;
        goal_r_d = 1'b0;
        winner_d = winner_q;
        case (state_q)
            S_IDLE: begin
                winner_d = 2'b00;
                if (start_rise) begin
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                state_d = S_PLAY;
            end
            S_PLAY: begin
                // Simultaneous goals replay the point: enter the pause without a pulse
                if (goal_l_rise || goal_r_rise) begin
                    state_d  = S_SCORED;
                    goal_l_d = goal_l_rise & ~goal_r_rise;
                    goal_r_d = goal_r_rise & ~goal_l_rise;
                end
            end
            S_SCORED: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == PAUSE_LAST) begin
                    cnt_d = '0;
                    if (score_l >= WIN_7) begin
                        winner_d = 2'b01;
                        state_d  = S_OVER;
                    end else if (score_r >= WIN_7) begin
                        winner_d = 2'b10;
                        state_d  = S_OVER;
                    end else begin
                        state_d = S_SERVE;
                    end
                end
            end
            S_OVER: begin
                if (start_rise) begin
                    state_d  = S_IDLE;
                    winner_d = 2'b00;
                end
            end
            default: begin
                state_d  = S_IDLE;
                winner_d = 2'b00;
            end
        endcase
    end

    // Level outputs are decoded from the next state so they line up with state_q
    always_comb begin
        serve_d     = (state_d == S_SERVE);
        ball_en_d   = (state_d == S_PLAY);
        dis_score_d = (state_d == S_SERVE) || (state_d == S_PLAY) ||
                      (state_d == S_SCORED) || (state_d == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q     <= 1'b0;
            goal_l_in_q <= 1'b0;
            goal_r_in_q <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            goal_l_q    <= 1'b0;
            goal_r_q    <= 1'b0;
            dis_score_q <= 1'b0;
            serve_q     <= 1'b0;
            ball_en_q   <= 1'b0;
            winner_q    <= 2'b00;
        end else begin
            start_q     <= bus.start;
            goal_l_in_q <= bus.goal_l_in;
            goal_r_in_q <= bus.goal_r_in;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            goal_l_q    <= goal_l_d;
            goal_r_q    <= goal_r_d;
            dis_score_q <= dis_score_d;
            serve_q     <= serve_d;
            ball_en_q   <= ball_en_d;
            winner_q    <= winner_d;
        end
    end

    assign bus.goal_l    = goal_l_q;
    assign bus.goal_r    = goal_r_q;
    assign bus.dis_score = dis_score_q;
    assign bus.serve     = serve_q;
    assign bus.ball_en   = ball_en_q;
    assign bus.state     = state_q;
    assign bus.winner    = winner_q;

endmodule
